// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB3 prescaled 32-bit timer/compare with level irq; APB_TIMER_WAIT_EN adds one wait state
module apb_timer #(
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

`ifdef APB_TIMER_WAIT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

  state_t                  state;
  logic                    err_q;
  logic                    en, autoreload, irqen, match;
  logic [PRESCALE_W-1:0]   prescale, pc;
  logic [31:0]             prescale_ext;
  logic [31:0]             count, compare;
  logic                    setup_req, in_done, start;
  logic                    addr_err;
  logic [31:0]             rd_mux;
  logic                    wr_hit, wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic                    tick, hit;

  // Address decode, read mux and the setup/completion conditions of the bus FSM
  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale;
    setup_req = PSEL & ~PENABLE;
`ifdef APB_TIMER_WAIT_EN
    in_done = (state == WAIT);
`else
    in_done = (state == ACCESS);
`endif
    // A new setup is accepted from IDLE or straight out of a completing cycle.
    start = setup_req & ((state == IDLE) | in_done);
    addr_err = (PADDR[1:0] != 2'd0) | (PADDR[11:5] != 7'd0) | (PADDR[4:2] > 3'd4);
    rd_mux = '0;
    if (!addr_err) begin
      case (PADDR[4:2])
        3'd0:    rd_mux = {29'd0, irqen, autoreload, en};
        3'd1:    rd_mux = prescale_ext;
        3'd2:    rd_mux = count;
        3'd3:    rd_mux = compare;
        3'd4:    rd_mux = {31'd0, match};
        default: rd_mux = '0;
      endcase
    end
  end

  // Write strobes: a write lands on the edge ending the cycle with PREADY high
  always_comb begin
    wr_hit      = PREADY & PSEL & PENABLE & PWRITE & ~err_q;
    wr_ctrl     = wr_hit & (PADDR[4:2] == 3'd0);
    wr_prescale = wr_hit & (PADDR[4:2] == 3'd1);
    wr_count    = wr_hit & (PADDR[4:2] == 3'd2);
    wr_compare  = wr_hit & (PADDR[4:2] == 3'd3);
    wr_status   = wr_hit & (PADDR[4:2] == 3'd4);
    // Clearing EN by a CTRL write swallows a tick due in the same cycle.
    tick = en & (pc == prescale) & ~(wr_ctrl & ~PWDATA[0]);
    hit  = tick & (count == compare);
  end

  // APB completer FSM with registered PRDATA/PREADY/PSLVERR
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else if (start) begin
      state  <= ACCESS;
      err_q  <= addr_err;
      PRDATA <= rd_mux;
`ifdef APB_TIMER_WAIT_EN
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
`else
      PREADY  <= 1'b1;
      PSLVERR <= addr_err;
`endif
    end
`ifdef APB_TIMER_WAIT_EN
    else if (state == ACCESS && PSEL) begin
      state   <= WAIT;
      PRDATA  <= rd_mux;
      PREADY  <= 1'b1;
      PSLVERR <= err_q;
    end
`endif
    else begin
      state   <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end
  end

  // Timer registers: prescaler, counter, compare/match and the interrupt level
  always_ff @(posedge clk) begin
    if (!rst) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      irqen      <= 1'b0;
      prescale   <= '0;
      pc         <= '0;
      count      <= '0;
      compare    <= COMPARE_RST;
      match      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= match & irqen;

      if (wr_ctrl | wr_prescale | tick) begin
        pc <= '0;
      end else if (en) begin
        pc <= pc + 1'b1;
      end

      // A bus write to COUNT overrides whatever the tick would have done.
      if (wr_count) begin
        count <= PWDATA;
      end else if (hit) begin
        if (autoreload) count <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
      end

      if (wr_ctrl) begin
        {irqen, autoreload, en} <= PWDATA[2:0];
      end else if (hit & ~autoreload) begin
        en <= 1'b0;
      end

      if (wr_prescale) prescale <= PWDATA[PRESCALE_W-1:0];
      if (wr_compare)  compare  <= PWDATA;

      // A fresh match beats a simultaneous write-1-to-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status & PWDATA[0]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - scoreboard testbench for apb_timer with a spec-level reference model
module tb_apb_timer;

`ifdef APB_TIMER_WAIT_EN
  localparam int AW = 2;
`else
  localparam int AW = 1;
`endif
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq;

  always #5 clk = ~clk;

  apb_timer dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq(irq)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  // per-cycle intent published by the driver for the model and monitor
  bit c_commit = 0, c_capture = 0, c_read = 0, c_ready = 0;
  bit mon_on = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  // reference model state
  int unsigned m_cnt, m_cmp, m_pre, m_pc;
  bit m_en, m_ar, m_ie, m_match, m_irq;

  function automatic bit bad(input logic [11:0] a);
    return (a[1:0] != 2'd0) || (a > 12'h010);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (bad(a)) return 32'd0;
    case (a)
      12'h000: return {29'd0, m_ie, m_ar, m_en};
      12'h004: return m_pre;
      12'h008: return m_cnt;
      12'h00C: return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  task automatic model_step();
    bit tick, hit, irq_next;
    logic [11:0] a;
    logic [31:0] d;
    a = PADDR;
    d = PWDATA;
    irq_next = m_match && m_ie;
    tick = m_en && (m_pc == m_pre);
    if (c_commit && a == 12'h000 && !d[0]) tick = 0;
    hit = tick && (m_cnt == m_cmp);
    if (tick) begin
      m_pc = 0;
      if (hit) begin
        m_match = 1;
        if (m_ar) m_cnt = 0;
        else m_en = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_en) begin
      m_pc = m_pc + 1;
    end
    if (c_commit) begin
      case (a)
        12'h000: begin {m_ie, m_ar, m_en} = d[2:0]; m_pc = 0; end
        12'h004: begin m_pre = d & PMASK; m_pc = 0; end
        12'h008: m_cnt = d;
        12'h00C: m_cmp = d;
        default: if (d[0] && !hit) m_match = 0;
      endcase
    end
    m_irq = irq_next;
  endtask

  // model: advances on every rising edge using the bus intent of the ending cycle
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_pre = 0; m_pc = 0;
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_irq = 0;
      end else begin
        if (c_capture) q.push_back('{rd: c_read, err: bad(PADDR), data: m_read(PADDR)});
        model_step();
      end
    end
  end

  // monitor: samples on the falling edge, pops the scoreboard on each PREADY
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("pready_timing", {31'd0, PREADY}, {31'd0, c_ready});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        if (PREADY === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got PREADY=1 expected no response");
          end else begin
            e = q.pop_front();
            chk("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
            if (e.rd || e.err) chk("prdata", PRDATA, e.data);
          end
          last_rdata = PRDATA;
          last_err   = PSLVERR;
        end else begin
          chk("pslverr_idle", {31'd0, PSLVERR}, 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      PSEL = 0; PENABLE = 0;
      c_commit = 0; c_capture = 0; c_ready = 0;
    end
  endtask

  task automatic xfer(input logic [11:0] a, input bit w, input logic [31:0] d);
    @(posedge clk); #1;
    PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d;
    c_ready = 0; c_commit = 0; c_read = !w; c_capture = (AW == 1);
    if (AW == 2) begin
      @(posedge clk); #1;
      PENABLE = 1; c_capture = 1;
    end
    @(posedge clk); #1;
    PENABLE = 1; c_capture = 0; c_ready = 1; c_commit = w && !bad(a);
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string name);
    xfer(a, 0, 32'd0);
    idle(1);
    chk(name, last_rdata, exp);
  endtask

  logic [11:0] ra;
  logic [31:0] rd;

  initial begin
    rst = 0; PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'h00C; PWDATA = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pready", {31'd0, PREADY}, 32'd0);
    chk("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1; PSEL = 0;
    mon_on = 1;
    rd_chk(12'h00C, 32'hFFFF_FFFF, "reset_compare");

    // one-shot with irq
    xfer(12'h004, 1, 32'd3);
    xfer(12'h00C, 1, 32'd2);
    xfer(12'h000, 1, 32'h5);
    idle(20);
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    rd_chk(12'h000, 32'h4, "oneshot_ctrl");
    rd_chk(12'h008, 32'd2, "oneshot_count");
    rd_chk(12'h010, 32'd1, "oneshot_match");
    xfer(12'h010, 1, 32'd1);
    xfer(12'h000, 1, 32'd0);
    idle(2);

    // auto-reload across the 32-bit wrap
    xfer(12'h008, 1, 32'hFFFF_FFFE);
    xfer(12'h00C, 1, 32'd5);
    xfer(12'h004, 1, 32'd0);
    xfer(12'h000, 1, 32'h3);
    repeat (6) xfer(12'h008, 0, 32'd0);
    idle(1);
    rd_chk(12'h010, 32'd1, "reload_match");
    chk("reload_irq_off", {31'd0, irq}, 32'd0);
    xfer(12'h000, 1, 32'd0);
    xfer(12'h010, 1, 32'd1);

    // W1C landing on a match tick
    xfer(12'h008, 1, 32'd0);
    xfer(12'h00C, 1, AW);
    xfer(12'h000, 1, 32'h3);
    xfer(12'h010, 1, 32'd1);
    rd_chk(12'h010, 32'd1, "w1c_collision");
    xfer(12'h000, 1, 32'd0);
    xfer(12'h010, 1, 32'd1);

    // COUNT write on a tick cycle
    xfer(12'h00C, 1, 32'hFFFF_FFFF);
    xfer(12'h000, 1, 32'h1);
    xfer(12'h008, 1, 32'h100);
    rd_chk(12'h008, (AW == 1) ? 32'h100 : 32'h101, "count_collision");
    xfer(12'h000, 1, 32'd0);

    // error responses
    xfer(12'h014, 1, 32'hDEAD_BEEF);
    idle(1);
    chk("err_wr_flag", {31'd0, last_err}, 32'd1);
    xfer(12'h006, 0, 32'd0);
    idle(1);
    chk("err_rd_flag", {31'd0, last_err}, 32'd1);
    chk("err_rd_data", last_rdata, 32'd0);

    // back-to-back write then read
    xfer(12'h00C, 1, 32'h1234_5678);
    rd_chk(12'h00C, 32'h1234_5678, "b2b_compare");

    // reset in the completing cycle of a write aborts it
    xfer(12'h00C, 1, 32'h0000_AAAA);
    rst = 0;
    @(posedge clk); #1;
    rst = 1; PSEL = 0; PENABLE = 0;
    c_commit = 0; c_capture = 0; c_ready = 0;
    rd_chk(12'h00C, 32'hFFFF_FFFF, "abort_compare");

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: ra = 12'($urandom_range(0, 4095));
        1, 2: ra = 12'h000;
        3: ra = 12'h004;
        4, 5: ra = 12'h008;
        6, 7: ra = 12'h00C;
        default: ra = 12'h010;
      endcase
      case (ra)
        12'h000: rd = $urandom_range(0, 7);
        12'h004: rd = $urandom_range(0, 3);
        12'h008: rd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom_range(0, 20);
        12'h00C: rd = $urandom_range(0, 20);
        default: rd = $urandom;
      endcase
      xfer(ra, bit'($urandom_range(0, 1)), rd);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(3);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
